// File: rtl/sc_ulpi_pkg.sv
// Shared ULPI definitions: register map, TX CMD prefixes, port modes and the
// register-control responder's state encoding.
package sc_ulpi_pkg;

    typedef enum logic [1:0] {
        tristateDrivers = 2'd0,
        hostFs          = 2'd1,
        hostChirp       = 2'd2,
        deviceHs        = 2'd3
    } usbPortMode_e;

    localparam logic [5:0] FUNC_CTRL = 6'h04;
    localparam logic [5:0] OTG_CTRL  = 6'h0A;

    localparam logic [1:0] REGWR = 2'b10;
    localparam logic [1:0] REGRD = 2'b11;

    localparam logic [7:0] OTG_HOST      = 8'h06;
    localparam logic [7:0] OTG_DEVICE    = 8'h00;
    localparam logic [7:0] FC_TRISTATE   = 8'h4D;
    localparam logic [7:0] FC_HOST_FS    = 8'h45;
    localparam logic [7:0] FC_HOST_CHIRP = 8'h50;

    typedef enum logic [3:0] {
        URC_IDLE,
        URC_WCMD,
        URC_WDATA,
        URC_WSTP,
        URC_RCMD,
        URC_RTURN,
        URC_RDATA,
        URC_RWAIT,
        URC_CHECK,
        URC_ABORT,
        URC_ACK
    } urc_state_e;

    typedef struct packed {
        logic       bad;
        logic [7:0] value;
    } fc_map_t;

    // Unsupported modes fall back to tristate drivers and are flagged.
    function automatic fc_map_t func_ctrl_byte(input usbPortMode_e mode);
        fc_map_t m;
        m.bad   = 1'b0;
        m.value = FC_TRISTATE;
        case (mode)
            tristateDrivers: m.value = FC_TRISTATE;
            hostFs:          m.value = FC_HOST_FS;
            hostChirp:       m.value = FC_HOST_CHIRP;
            default:         m.bad   = 1'b1;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/sc_scbc_urc.sv
// ULPI register-control responder: turns each UPSI request into a RegWrite
// plus verifying RegRead, with retries, NXT timeout and a one-cycle ACK.
module sc_scbc_urc
    import sc_ulpi_pkg::*;
#(
    parameter int MAX_RETRY   = 3,
    parameter int NXT_TIMEOUT = 255
) (
    input  logic         ULPICLK,
    input  logic         ULPIRST,
    input  logic         UPSI_REQ,
    output logic         UPSI_ACK,
    input  logic         UPSI_TYPE,
    input  usbPortMode_e UPSI_STATE,
    input  logic         UPSI_CFG,
    output logic [7:0]   URC_DATA,
    output logic         URC_ERR,
    output logic         URC_BUSY,
    input  logic         ULPI_DIR,
    input  logic         ULPI_NXT,
    input  logic [7:0]   ULPI_DATA_I,
    output logic [7:0]   ULPI_DATA_O,
    output logic         ULPI_DATA_OE,
    output logic         ULPI_STP
);

    localparam int RETRY_W = $clog2(MAX_RETRY + 1);
    localparam int TMO_W   = $clog2(NXT_TIMEOUT + 1);
    localparam logic [TMO_W-1:0]   TMO_LAST    = TMO_W'(NXT_TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);
    localparam logic [RETRY_W-1:0] RETRY_FINAL = RETRY_W'(MAX_RETRY - 1);

    urc_state_e         state_reg, state_next;
    logic [RETRY_W-1:0] retry_reg, retry_next;
    logic [TMO_W-1:0]   tmo_reg, tmo_next;
    logic [5:0]         addr_reg, addr_next;
    logic [7:0]         value_reg, value_next;
    logic [7:0]         data_reg, data_next;
    logic               err_reg, err_next;

    logic               drive_oe;
    logic [7:0]         drive_data;
    logic               stp_int;
    logic               ack_int;
    logic               tmo_expired;
    fc_map_t            fc_map;

    assign tmo_expired = (tmo_reg == TMO_LAST);

    always_ff @(posedge ULPICLK) begin
        if (ULPIRST) begin
            state_reg <= URC_IDLE;
            retry_reg <= '0;
            tmo_reg   <= '0;
            addr_reg  <= '0;
            value_reg <= '0;
            data_reg  <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            retry_reg <= retry_next;
            tmo_reg   <= tmo_next;
            addr_reg  <= addr_next;
            value_reg <= value_next;
            data_reg  <= data_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        retry_next = retry_reg;
        tmo_next   = tmo_reg;
        addr_next  = addr_reg;
        value_next = value_reg;
        data_next  = data_reg;
        err_next   = err_reg;
        drive_oe   = 1'b0;
        drive_data = 8'h00;
        stp_int    = 1'b0;
        ack_int    = 1'b0;
        fc_map     = func_ctrl_byte(UPSI_STATE);

        case (state_reg)
            URC_IDLE: begin
                if (UPSI_REQ) begin
                    retry_next = '0;
                    tmo_next   = '0;
                    state_next = URC_WCMD;
                    if (UPSI_TYPE) begin
                        addr_next  = FUNC_CTRL;
                        value_next = fc_map.value;
                        if (fc_map.bad) err_next = 1'b1;
                    end else begin
                        addr_next  = OTG_CTRL;
                        value_next = UPSI_CFG ? OTG_DEVICE : OTG_HOST;
                    end
                end
            end
            URC_WCMD, URC_WDATA, URC_RCMD: begin
                drive_oe = 1'b1;
                if (state_reg == URC_WCMD)       drive_data = {REGWR, addr_reg};
                else if (state_reg == URC_WDATA) drive_data = value_reg;
                else                             drive_data = {REGRD, addr_reg};
                // DIR rising here is an RX CMD taking the bus; a silent PHY is treated the same way.
                if (ULPI_DIR || (!ULPI_NXT && tmo_expired)) begin
                    retry_next = retry_reg + 1'b1;
                    tmo_next   = '0;
                    state_next = URC_ABORT;
                end else if (ULPI_NXT) begin
                    tmo_next = '0;
                    if (state_reg == URC_WCMD)       state_next = URC_WDATA;
                    else if (state_reg == URC_WDATA) state_next = URC_WSTP;
                    else                             state_next = URC_RTURN;
                end else begin
                    tmo_next = tmo_reg + 1'b1;
                end
            end
            URC_WSTP: begin
                drive_oe   = 1'b1;
                stp_int    = 1'b1;
                state_next = URC_RCMD;
            end
            URC_RTURN: begin
                // Bounded so a PHY that never turns the bus around cannot stall the requester.
                if (ULPI_DIR) begin
                    tmo_next   = '0;
                    state_next = URC_RDATA;
                end else if (tmo_expired) begin
                    retry_next = retry_reg + 1'b1;
                    tmo_next   = '0;
                    state_next = URC_ABORT;
                end else begin
                    tmo_next = tmo_reg + 1'b1;
                end
            end
            URC_RDATA: begin
                data_next  = ULPI_DATA_I;
                state_next = URC_RWAIT;
            end
            URC_RWAIT: begin
                if (!ULPI_DIR) state_next = URC_CHECK;
            end
            URC_CHECK: begin
                if (data_reg == value_reg) begin
                    state_next = URC_ACK;
                end else begin
                    retry_next = retry_reg + 1'b1;
                    if (retry_reg >= RETRY_FINAL) begin
                        err_next   = 1'b1;
                        state_next = URC_ACK;
                    end else begin
                        state_next = URC_WCMD;
                    end
                end
            end
            URC_ABORT: begin
                if (!ULPI_DIR) begin
                    if (retry_reg >= RETRY_MAX) begin
                        err_next   = 1'b1;
                        state_next = URC_ACK;
                    end else begin
                        state_next = URC_WCMD;
                    end
                end
            end
            URC_ACK: begin
                ack_int    = 1'b1;
                retry_next = '0;
                state_next = URC_IDLE;
            end
            default: state_next = URC_IDLE;
        endcase
    end

    assign ULPI_DATA_OE = drive_oe & ~ULPI_DIR;
    assign ULPI_DATA_O  = ULPI_DATA_OE ? drive_data : 8'h00;
    assign ULPI_STP     = stp_int;
    assign UPSI_ACK     = ack_int;
    assign URC_BUSY     = (state_reg != URC_IDLE);
    assign URC_DATA     = data_reg;
    assign URC_ERR      = err_reg;

endmodule
